// File: rtl/iiitb_sync_fifo_pkg.sv
// Shared sizing defaults for the synchronous byte FIFO.
package iiitb_sync_fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_ADDR_W = $clog2(FIFO_DEPTH);

endpackage : iiitb_sync_fifo_pkg

// File: rtl/iiitb_sync_fifo_mem.sv
// DEPTH x DATA_W register array with a synchronous write port and a
// registered read port. The read register is cleared on reset; the
// storage array itself is not.
module iiitb_sync_fifo_mem
  import iiitb_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage write on an accepted push.
  // NOTE: the array has no reset branch; stale entries are unreachable once the
  // pointers and count are cleared, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next read-data value: head entry on an accepted pop, otherwise hold.
  // NOTE: the default assignment comes first so no path leaves rd_data_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Read-data register with synchronous clear.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : iiitb_sync_fifo_mem

// File: rtl/iiitb_sync_fifo.sv
// Single-clock byte FIFO: pointer, occupancy count and flag logic around a
// register-array storage block. Requests that would overflow or underflow
// are dropped without side effects.
module iiitb_sync_fifo
  import iiitb_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTn,   // active-high synchronous reset
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              wr_en;
  logic              rd_en;

  // Flags from the current count; acceptance uses pre-edge flags and is
  // suppressed during reset so reset overrides any request.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    wr_en = write & ~full  & ~RSTn;
    rd_en = read  & ~empty & ~RSTn;
  end

  // Next-state pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  iiitb_sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (CLK),
    .rst     (RSTn),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (iData),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (oData)
  );

endmodule : iiitb_sync_fifo

// File: tb/tb_iiitb_sync_fifo.sv
// Scoreboard bench for iiitb_sync_fifo: stimulus pushes hand-computed read
// data into a queue, a negedge monitor pops and compares each popped byte.
module tb_iiitb_sync_fifo;

  logic       CLK;
  logic       RSTn;
  logic       write;
  logic       read;
  logic [7:0] iData;
  logic [7:0] oData;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  logic       pend = 1'b0;

  iiitb_sync_fifo dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .write (write),
    .read  (read),
    .iData (iData),
    .oData (oData),
    .full  (full),
    .empty (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an accepted pop seen at one negedge is compared at the next.
  always @(negedge CLK) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got oData 0x%0h expected no pop at %0t", oData, $time);
      end else begin
        check("pop_data", {24'h0, oData}, {24'h0, exp_q.pop_front()});
      end
    end
    pend <= read && !empty && !RSTn;
  end

  // Drive one cycle of inputs and return 1 time unit after the edge.
  task automatic drive(input logic rst, input logic w, input logic r, input logic [7:0] d);
    RSTn  = rst;
    write = w;
    read  = r;
    iData = d;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] wr_seq;
  logic [7:0] rd_seq;

  initial begin
    // Reset held two cycles with both requests asserted.
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_odata", oData, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    check("rst_nothing_stored", empty, 1);

    // Fill with 0x01..0x10, then an overflow attempt.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(i));
      check("fill_empty", empty, 0);
      check("fill_full",  full,  (i == 16) ? 1 : 0);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h11);
    check("overflow_full", full, 1);

    // Drain 17 times; the last read underflows and oData holds 0x10.
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back(8'(i));
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      if (i == 1)  check("drain_full_clear", full, 0);
      if (i == 15) check("drain_not_empty", empty, 0);
      if (i == 16) check("drain_empty", empty, 1);
    end
    check("underflow_hold", oData, 8'h10);

    // Simultaneous read/write while empty: write only.
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    check("empty_rw_empty", empty, 0);
    check("empty_rw_hold",  oData, 8'h10);
    exp_q.push_back(8'hA5);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    check("empty_rw_count1", empty, 1);

    // Simultaneous read/write while full: read only.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i));
    check("refill_full", full, 1);
    exp_q.push_back(8'h20);
    drive(1'b0, 1'b1, 1'b1, 8'hEE);
    check("full_rw_full", full, 0);
    drive(1'b0, 1'b1, 1'b0, 8'hF0);
    check("full_rw_count15", full, 1);
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      drive(1'b0, 1'b0, 1'b1, 8'h00);
    end
    exp_q.push_back(8'hF0);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    check("full_rw_drained", empty, 1);

    // Mid-operation reset discards stored entries.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'h50 + 8'(i));
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("midrst_empty", empty, 1);
    check("midrst_odata", oData, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    exp_q.push_back(8'h3C);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    check("midrst_empty_after", empty, 1);

    // Streaming across several pointer wraps.
    wr_seq = 8'h00;
    rd_seq = 8'h00;
    for (int i = 0; i < 100; i++) begin
      logic w;
      logic r;
      w = !full;
      r = !empty;
      if (r) begin
        exp_q.push_back(rd_seq);
        rd_seq++;
      end
      drive(1'b0, w, r, wr_seq);
      if (w) wr_seq++;
    end
    check("stream_count", {24'h0, rd_seq}, 32'd99);

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_iiitb_sync_fifo

// File: doc/iiitb_sync_fifo.md
Name: iiitb_sync_fifo

Overview:
Single-clock, first-in-first-out byte buffer. It decouples a producer and a consumer that share clock CLK. It accepts one byte per cycle on write and returns one byte per cycle on read. Status flags full and empty let the surrounding logic throttle its write and read requests.

Parameters:
DATA_W, 8, width of iData/oData and of each storage entry.
DEPTH, 16, number of storage entries; must be a power of two, at least 2.
ADDR_W, 4, equals log2(DEPTH); width of the read and write pointers.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTn  input  1  synchronous reset, active-high (1 = reset) despite the legacy name; sampled on the rising edge of CLK.
write  input  1  write request; iData is stored on the same edge when accepted.
read  input  1  read request; the head entry is popped when accepted.
iData  input  DATA_W  write data.
oData  output  DATA_W  registered read data.
full  output  1  1 when the FIFO holds DEPTH entries.
empty  output  1  1 when the FIFO holds 0 entries.

Behaviour:
- State: storage array mem[DEPTH], wr_ptr and rd_ptr (ADDR_W bits each), count (ADDR_W+1 bits, range 0..DEPTH), oData register.
- Reset (RSTn=1 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, oData=0. Hence empty=1 and full=0 from the following cycle. Storage contents are not reset. Reset overrides any write or read in the same cycle.
- Flags are combinational from count: empty = (count==0), full = (count==DEPTH).
- Write acceptance: wr_en = write & ~full, using the flag value before the edge. When wr_en: mem[wr_ptr] <= iData and wr_ptr <= wr_ptr+1.
- Read acceptance: rd_en = read & ~empty, using the flag value before the edge. When rd_en: oData <= mem[rd_ptr] and rd_ptr <= rd_ptr+1.
- When not rd_en, oData holds its last value.
- Read latency: data is visible on oData one cycle after the accepting edge.
- Pointer wrap: pointers increment modulo DEPTH (natural ADDR_W-bit rollover).
- Count update: +1 if wr_en only, -1 if rd_en only, unchanged if both or neither.
- Simultaneous read and write when neither flag is set: both are accepted and count is unchanged.
- Simultaneous read and write when empty: the write is accepted, the read is ignored, oData holds, and count becomes 1. There is no write-to-read bypass.
- Simultaneous read and write when full: the read is accepted (oData gets the head), the write is ignored, and count becomes DEPTH-1.
- Overflow or underflow attempts are silently dropped. There is no error flag, and the pointers and count never change on a rejected request.
- Reset mid-operation discards all stored entries; empty asserts from the next cycle.

Decomposition:
- Shared package: DATA_W and DEPTH defaults, and ADDR_W derived with $clog2.
- No typedefs are required.
- One natural sub-module: fifo_mem, a DEPTH x DATA_W register array with a synchronous write port and a registered read port.
- Pointer, count and flag logic stays in iiitb_sync_fifo.

Test Plan:
- Reset: hold RSTn=1 for 2 cycles with write=1 and read=1 -> empty=1, full=0, oData=0; no entry stored.
- Fill: after reset, write 0x01..0x10 on 16 consecutive cycles with read=0 -> full=1 after the 16th edge, empty=0; a 17th write of 0x11 is ignored and count stays 16.
- Drain: from full, read=1 for 17 cycles -> oData steps 0x01..0x10 with one-cycle latency; empty=1 after the 16th pop; the 17th read leaves oData=0x10.
- Streaming: write=~full and read=~empty each cycle with an incrementing iData from 0x00 -> oData reproduces the sequence 0x00,0x01,... in order with no loss or duplication over 100 cycles, across multiple pointer wraps.
- Boundary simultaneity: when empty, assert write (0xA5) and read together -> count becomes 1 and oData is unchanged. When full, assert both -> the head is popped, the write is dropped, and count becomes 15.
- Mid-operation reset: load 5 entries, assert RSTn for one cycle -> empty=1, oData=0; a subsequent write of 0x3C followed by a read yields 0x3C.
